// File: rtl/shift_register_transmitter.sv
// shift_register_transmitter
//
// Parallel-in, serial-out transmitter driving a serial data / clock / latch
// interface. A DEPTH-bit word is accepted over a valid/ready handshake and
// shifted out MSB-first on sdata. A generated sclk runs at CLK_DIV clk cycles
// per half-period. An optional latch strobe of LATCH_CYCLES clk cycles follows
// the word.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high; priority over all other inputs
//   data_in     word to transmit, bit DEPTH-1 goes first
//   data_last   captured with data_in; 1 = pulse latch after this word
//   data_valid  data_in / data_last are valid
//   data_ready  transmitter can accept a word (IDLE and not in reset)
//   sclk        serial clock; the receiver samples sdata on its rising edge
//   sdata       serial data
//   latch       latch strobe, active-high
//   busy        high whenever the FSM is not IDLE
//
// Handshake: a word is transferred on a rising clk edge where data_valid and
// data_ready are both high. The source must hold data_valid and its data
// stable until that edge. data_valid while data_ready is low has no effect.
//
// State machine:
//   IDLE  -> LOW    on handshake; sdata takes the MSB, sclk stays 0
//   LOW   -> HIGH   after CLK_DIV cycles; sclk rises, sdata held
//   HIGH  -> LOW    after CLK_DIV cycles while bits remain; next bit
//   HIGH  -> LATCH  after the last bit when the captured last flag is set
//   HIGH  -> IDLE   after the last bit otherwise
//   LATCH -> IDLE   after LATCH_CYCLES cycles
// sclk, sdata and latch are registered. Their next values are computed in
// the same edge as the state transition that defines them.

module shift_register_transmitter #(
  parameter int DEPTH        = 8,
  parameter int CLK_DIV      = 4,
  parameter int LATCH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DEPTH-1:0] data_in,
  input  logic             data_last,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             sclk,
  output logic             sdata,
  output logic             latch,
  output logic             busy
);

  // ---------------------------------------------------------------------------
  // Parameter checks
  // ---------------------------------------------------------------------------
  if (DEPTH < 2) begin : g_bad_depth
    $error("shift_register_transmitter: DEPTH must be 2 or more");
  end
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("shift_register_transmitter: CLK_DIV must be 1 or more");
  end
  if (LATCH_CYCLES < 1) begin : g_bad_latch_cycles
    $error("shift_register_transmitter: LATCH_CYCLES must be 1 or more");
  end

  // ---------------------------------------------------------------------------
  // Widths and constants
  // ---------------------------------------------------------------------------
  localparam int PHASE_MAX = (CLK_DIV > LATCH_CYCLES) ? CLK_DIV : LATCH_CYCLES;
  localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
  localparam int BIT_W     = $clog2(DEPTH);

  // Phase counter counts 0 .. N-1 inside a phase of N cycles.
  localparam logic [PHASE_W-1:0] HALF_END  = PHASE_W'(CLK_DIV - 1);
  localparam logic [PHASE_W-1:0] LATCH_END = PHASE_W'(LATCH_CYCLES - 1);
  localparam logic [PHASE_W-1:0] PHASE_ONE = PHASE_W'(1);
  localparam logic [BIT_W-1:0]   BIT_FIRST = BIT_W'(DEPTH - 1);
  localparam logic [BIT_W-1:0]   BIT_ONE   = BIT_W'(1);
  localparam logic [BIT_W-1:0]   BIT_ZERO  = '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOW   = 2'd1,
    S_HIGH  = 2'd2,
    S_LATCH = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t             state;
  state_t             state_d;
  logic [PHASE_W-1:0] phase_cnt;
  logic [PHASE_W-1:0] phase_d;
  logic [BIT_W-1:0]   bit_cnt;
  logic [BIT_W-1:0]   bit_d;
  logic [DEPTH-1:0]   shift_q;
  logic [DEPTH-1:0]   shift_d;
  logic               last_q;
  logic               last_d;
  logic               sclk_d;
  logic               sdata_d;
  logic               latch_d;

  logic               accept;
  logic               phase_done;

  // A word is taken only from IDLE; reset wins through the register block.
  assign accept = (state == S_IDLE) && data_valid;

  // LOW and HIGH run for CLK_DIV cycles, LATCH for LATCH_CYCLES cycles.
  always_comb begin
    phase_done = 1'b0;
    case (state)
      S_LOW, S_HIGH: phase_done = (phase_cnt == HALF_END);
      S_LATCH:       phase_done = (phase_cnt == LATCH_END);
      default:       phase_done = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Process 1: state register (and the registers that travel with it)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      phase_cnt <= '0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      last_q    <= 1'b0;
      sclk      <= 1'b0;
      sdata     <= 1'b0;
      latch     <= 1'b0;
    end else begin
      state     <= state_d;
      phase_cnt <= phase_d;
      bit_cnt   <= bit_d;
      shift_q   <= shift_d;
      last_q    <= last_d;
      sclk      <= sclk_d;
      sdata     <= sdata_d;
      latch     <= latch_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Process 2: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: begin
        if (accept) state_d = S_LOW;
      end
      S_LOW: begin
        if (phase_done) state_d = S_HIGH;
      end
      S_HIGH: begin
        if (phase_done) begin
          if (bit_cnt != BIT_ZERO) state_d = S_LOW;
          else if (last_q)         state_d = S_LATCH;
          else                     state_d = S_IDLE;
        end
      end
      S_LATCH: begin
        if (phase_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next values for the counters, shift register and registered outputs.
  // They follow the transitions chosen above so that sclk/sdata/latch change
  // on the same edge that enters the new state.
  // ---------------------------------------------------------------------------
  always_comb begin
    phase_d = phase_cnt;
    bit_d   = bit_cnt;
    shift_d = shift_q;
    last_d  = last_q;
    sclk_d  = sclk;
    sdata_d = sdata;
    latch_d = latch;

    case (state)
      S_IDLE: begin
        phase_d = '0;
        sclk_d  = 1'b0;
        sdata_d = 1'b0;
        latch_d = 1'b0;
        if (accept) begin
          shift_d = data_in;
          last_d  = data_last;
          bit_d   = BIT_FIRST;
          // The MSB is presented at the accepting edge so it has a full
          // LOW phase of setup before the first sclk rise.
          sdata_d = data_in[DEPTH-1];
        end
      end

      S_LOW: begin
        if (phase_done) begin
          phase_d = '0;
          sclk_d  = 1'b1;
        end else begin
          phase_d = phase_cnt + PHASE_ONE;
        end
      end

      S_HIGH: begin
        if (phase_done) begin
          phase_d = '0;
          sclk_d  = 1'b0;
          if (bit_cnt != BIT_ZERO) begin
            // sdata moves only on the falling sclk edge, giving a full
            // half-period of hold after the rising edge.
            bit_d   = bit_cnt - BIT_ONE;
            shift_d = shift_q << 1;
            sdata_d = shift_q[DEPTH-2];
          end else begin
            sdata_d = 1'b0;
            latch_d = last_q;
          end
        end else begin
          phase_d = phase_cnt + PHASE_ONE;
        end
      end

      S_LATCH: begin
        sclk_d  = 1'b0;
        sdata_d = 1'b0;
        if (phase_done) begin
          phase_d = '0;
          latch_d = 1'b0;
        end else begin
          phase_d = phase_cnt + PHASE_ONE;
          latch_d = 1'b1;
        end
      end

      default: begin
        phase_d = '0;
        sclk_d  = 1'b0;
        sdata_d = 1'b0;
        latch_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Process 3: state-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    data_ready = (state == S_IDLE) && !reset;
    busy       = (state != S_IDLE);
  end

endmodule

// File: tb/tb_shift_register_transmitter.sv
// Testbench for shift_register_transmitter.
// Two instances: the default configuration (8 bits, CLK_DIV=4, LATCH_CYCLES=2)
// and the smallest corner (2 bits, CLK_DIV=1, LATCH_CYCLES=1).
// Expected waveforms come from a cycle-index formula derived from the
// serial timing rules; expected bits come from a queue filled from the words.

module tb_shift_register_transmitter;

  localparam int DW = 8;
  localparam int CD = 4;
  localparam int LC = 2;
  localparam int WORD_CYCLES = 2 * CD * DW;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Default instance
  logic [DW-1:0] d_in = '0;
  logic          d_last = 1'b0;
  logic          d_valid = 1'b0;
  logic          d_ready;
  logic          sclk, sdata, latch, busy;

  // Corner instance
  logic [1:0] c_in = '0;
  logic       c_last = 1'b0;
  logic       c_valid = 1'b0;
  logic       c_ready;
  logic       c_sclk, c_sdata, c_latch, c_busy;

  shift_register_transmitter #(.DEPTH(DW), .CLK_DIV(CD), .LATCH_CYCLES(LC)) dut (
    .clk(clk), .reset(reset), .data_in(d_in), .data_last(d_last),
    .data_valid(d_valid), .data_ready(d_ready), .sclk(sclk), .sdata(sdata),
    .latch(latch), .busy(busy)
  );

  shift_register_transmitter #(.DEPTH(2), .CLK_DIV(1), .LATCH_CYCLES(1)) dut_c (
    .clk(clk), .reset(reset), .data_in(c_in), .data_last(c_last),
    .data_valid(c_valid), .data_ready(c_ready), .sclk(c_sclk), .sdata(c_sdata),
    .latch(c_latch), .busy(c_busy)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad = 0;

  logic [0:0] exp_q[$];   // expected serial bits, in order
  logic [0:0] got_q[$];   // bits seen at sclk rising edges
  logic [0:0] got2_q[$];  // corner instance bits
  logic [4:0] obs_q[$];   // per-cycle {sclk, sdata, latch, busy, ready}
  int         rise_cnt = 0;
  logic [DW-1:0] rx = '0;          // loopback receive shift register
  logic [DW-1:0] rx_at_latch = '0;

  always @(posedge sclk) begin
    got_q.push_back(sdata);
    rx <= {rx[DW-2:0], sdata};
    rise_cnt++;
  end
  always @(posedge c_sclk) got2_q.push_back(c_sdata);
  always @(posedge latch) rx_at_latch = rx;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected {sclk, sdata, latch, busy} k cycles after the accepting edge.
  // Each bit occupies 2*CD cycles: CD low then CD high.
  function automatic logic [3:0] model_at(input logic [DW-1:0] w, input logic l,
                                          input int k);
    int b, p;
    if (k >= 1 && k <= WORD_CYCLES) begin
      b = (k - 1) / (2 * CD);
      p = (k - 1) % (2 * CD);
      return {(p >= CD), w[DW-1-b], 1'b0, 1'b1};
    end
    if (l && k > WORD_CYCLES && k <= WORD_CYCLES + LC) return 4'b0011;
    return 4'b0000;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: send one word and record every cycle until busy drops.
  // ---------------------------------------------------------------------------
  task automatic xfer(input logic [DW-1:0] w, input logic l, input bit scramble);
    int guard;
    obs_q.delete();
    @(negedge clk);
    guard = 0;
    while (!d_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    d_in = w;
    d_last = l;
    d_valid = 1'b1;
    for (int i = DW - 1; i >= 0; i--) exp_q.push_back(w[i]);
    @(negedge clk);
    d_valid = 1'b0;
    d_last = 1'b0;
    obs_q.push_back({sclk, sdata, latch, busy, d_ready});
    guard = 0;
    while (busy && guard < 500) begin
      if (scramble) d_in = DW'($urandom);
      @(negedge clk);
      guard++;
      obs_q.push_back({sclk, sdata, latch, busy, d_ready});
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset;
    logic [4:0] first;
    int changes;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (d_ready !== 1'b0) begin
      bad++; $display("FAIL reset_ready_in_reset got=%b want=0", d_ready);
    end
    reset = 1'b0;
    #1;
    total++;
    if ({sclk, sdata, latch, busy, d_ready} !== 5'b00001) begin
      bad++; $display("FAIL reset_outputs got=%b want=00001", {sclk, sdata, latch, busy, d_ready});
    end
    total++;
    if ({c_sclk, c_sdata, c_latch, c_busy, c_ready} !== 5'b00001) begin
      bad++; $display("FAIL reset_outputs_corner got=%b want=00001",
                      {c_sclk, c_sdata, c_latch, c_busy, c_ready});
    end
    first = {sclk, sdata, latch, busy, d_ready};
    changes = 0;
    repeat (100) begin
      @(negedge clk);
      if ({sclk, sdata, latch, busy, d_ready} !== first) changes++;
    end
    total++;
    if (changes !== 0) begin
      bad++; $display("FAIL idle_static changed_cycles=%0d want=0", changes);
    end
  endtask

  task automatic test_single;
    logic [3:0] m;
    logic e, g;
    exp_q.delete(); got_q.delete();
    xfer(8'hA5, 1'b0, 1'b0);
    total++;
    if (obs_q.size() !== WORD_CYCLES + 1) begin
      bad++; $display("FAIL single_len got=%0d want=%0d", obs_q.size(), WORD_CYCLES + 1);
    end
    for (int k = 1; k <= obs_q.size(); k++) begin
      m = model_at(8'hA5, 1'b0, k);
      total++;
      if (obs_q[k-1] !== {m, ~m[0]}) begin
        bad++; $display("FAIL single_wave k=%0d got=%b want=%b", k, obs_q[k-1], {m, ~m[0]});
      end
    end
    total++;
    if (got_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL single_bitcount got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total++;
      if (g !== e) begin bad++; $display("FAIL single_bit got=%b want=%b", g, e); end
    end
  endtask

  task automatic test_latch;
    logic [3:0] m;
    logic e, g;
    exp_q.delete(); got_q.delete();
    rx_at_latch = '0;
    xfer(8'h3C, 1'b1, 1'b0);
    total++;
    if (obs_q.size() !== WORD_CYCLES + LC + 1) begin
      bad++; $display("FAIL latch_len got=%0d want=%0d", obs_q.size(), WORD_CYCLES + LC + 1);
    end
    for (int k = 1; k <= obs_q.size(); k++) begin
      m = model_at(8'h3C, 1'b1, k);
      total++;
      if (obs_q[k-1] !== {m, ~m[0]}) begin
        bad++; $display("FAIL latch_wave k=%0d got=%b want=%b", k, obs_q[k-1], {m, ~m[0]});
      end
    end
    total++;
    if (rx_at_latch !== 8'h3C) begin
      bad++; $display("FAIL latch_loopback got=%h want=3c", rx_at_latch);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total++;
      if (g !== e) begin bad++; $display("FAIL latch_bit got=%b want=%b", g, e); end
    end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] words[3];
    logic [3:0] m;
    logic [4:0] o;
    int guard, wi, k;
    logic e, g;
    words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'hFF;
    exp_q.delete(); got_q.delete();
    for (int i = 0; i < 3; i++)
      for (int b = DW - 1; b >= 0; b--) exp_q.push_back(words[i][b]);
    @(negedge clk);
    guard = 0;
    while (!d_ready && guard < 500) begin @(negedge clk); guard++; end
    d_in = words[0]; d_last = 1'b0; d_valid = 1'b1;
    // Cycle j after the first accept: each word takes WORD_CYCLES busy cycles
    // followed by exactly one idle cycle in which the next word is accepted.
    for (int j = 1; j <= 3 * (WORD_CYCLES + 1); j++) begin
      @(negedge clk);
      wi = (j - 1) / (WORD_CYCLES + 1);
      k = (j - 1) % (WORD_CYCLES + 1) + 1;
      m = model_at(words[wi], 1'b0, k);
      o = {sclk, sdata, latch, busy, d_ready};
      total++;
      if (o !== {m, ~m[0]}) begin
        bad++; $display("FAIL b2b_wave word=%0d k=%0d got=%b want=%b", wi, k, o, {m, ~m[0]});
      end
      if (k == WORD_CYCLES + 1) begin
        if (wi < 2) d_in = words[wi + 1];
        else d_valid = 1'b0;
      end else begin
        d_in = DW'($urandom);
      end
    end
    d_valid = 1'b0;
    total++;
    if (got_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL b2b_bitcount got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total++;
      if (g !== e) begin bad++; $display("FAIL b2b_bit got=%b want=%b", g, e); end
    end
  endtask

  task automatic test_reset_mid;
    int guard, start, latch_seen;
    logic [3:0] m;
    logic e, g;
    @(negedge clk);
    start = rise_cnt;
    d_in = 8'hF0; d_last = 1'b1; d_valid = 1'b1;
    @(negedge clk);
    d_valid = 1'b0; d_last = 1'b0;
    guard = 0;
    while (rise_cnt < start + 3 && guard < 500) begin @(negedge clk); guard++; end
    total++;
    if (rise_cnt !== start + 3) begin
      bad++; $display("FAIL rmid_rises got=%0d want=3", rise_cnt - start);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({sclk, sdata, latch, busy, d_ready} !== 5'b00000) begin
      bad++; $display("FAIL rmid_after_reset got=%b want=00000", {sclk, sdata, latch, busy, d_ready});
    end
    reset = 1'b0;
    #1;
    total++;
    if (d_ready !== 1'b1) begin
      bad++; $display("FAIL rmid_ready got=%b want=1", d_ready);
    end
    latch_seen = 0;
    repeat (WORD_CYCLES) begin
      @(negedge clk);
      if (latch || busy) latch_seen++;
    end
    total++;
    if (latch_seen !== 0) begin
      bad++; $display("FAIL rmid_quiet active_cycles=%0d want=0", latch_seen);
    end
    exp_q.delete(); got_q.delete();
    xfer(8'h55, 1'b0, 1'b1);
    total++;
    if (obs_q.size() !== WORD_CYCLES + 1) begin
      bad++; $display("FAIL rmid_len got=%0d want=%0d", obs_q.size(), WORD_CYCLES + 1);
    end
    for (int k = 1; k <= obs_q.size(); k++) begin
      m = model_at(8'h55, 1'b0, k);
      total++;
      if (obs_q[k-1] !== {m, ~m[0]}) begin
        bad++; $display("FAIL rmid_wave k=%0d got=%b want=%b", k, obs_q[k-1], {m, ~m[0]});
      end
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total++;
      if (g !== e) begin bad++; $display("FAIL rmid_bit got=%b want=%b", g, e); end
    end
  endtask

  task automatic test_random;
    logic [DW-1:0] w;
    logic l;
    logic [3:0] m;
    int want_len;
    logic e, g;
    for (int n = 0; n < 12; n++) begin
      w = DW'($urandom);
      l = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      exp_q.delete(); got_q.delete();
      xfer(w, l, 1'b1);
      want_len = WORD_CYCLES + (l ? LC : 0) + 1;
      total++;
      if (obs_q.size() !== want_len) begin
        bad++; $display("FAIL rand_len w=%h l=%b got=%0d want=%0d", w, l, obs_q.size(), want_len);
      end
      for (int k = 1; k <= obs_q.size(); k++) begin
        m = model_at(w, l, k);
        total++;
        if (obs_q[k-1] !== {m, ~m[0]}) begin
          bad++; $display("FAIL rand_wave w=%h k=%0d got=%b want=%b", w, k, obs_q[k-1], {m, ~m[0]});
        end
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
        e = exp_q.pop_front(); g = got_q.pop_front();
        total++;
        if (g !== e) begin bad++; $display("FAIL rand_bit w=%h got=%b want=%b", w, g, e); end
      end
    end
  endtask

  task automatic test_corner;
    // {sclk, sdata, latch, busy} per cycle for word 2'b10 with latch:
    // low/high for bit 1, low/high for bit 0, one latch cycle, then idle.
    logic [3:0] want[6];
    logic [3:0] o;
    int busy_cycles;
    want[0] = 4'b0101; want[1] = 4'b1101; want[2] = 4'b0001;
    want[3] = 4'b1001; want[4] = 4'b0011; want[5] = 4'b0000;
    got2_q.delete();
    @(negedge clk);
    c_in = 2'b10; c_last = 1'b1; c_valid = 1'b1;
    @(negedge clk);
    c_valid = 1'b0; c_last = 1'b0;
    busy_cycles = 0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      o = {c_sclk, c_sdata, c_latch, c_busy};
      if (c_busy) busy_cycles++;
      total++;
      if (o !== want[k]) begin
        bad++; $display("FAIL corner_wave k=%0d got=%b want=%b", k + 1, o, want[k]);
      end
    end
    total++;
    if (busy_cycles !== 5) begin
      bad++; $display("FAIL corner_busy got=%0d want=5", busy_cycles);
    end
    total++;
    if (got2_q.size() !== 2) begin
      bad++; $display("FAIL corner_bitcount got=%0d want=2", got2_q.size());
    end else begin
      total++;
      if ({got2_q[0], got2_q[1]} !== 2'b10) begin
        bad++; $display("FAIL corner_bits got=%b%b want=10", got2_q[0], got2_q[1]);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset;
    test_single;
    test_latch;
    test_back_to_back;
    test_reset_mid;
    test_random;
    test_corner;
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
